// File: rtl/demux_router_pkg.sv
// rtl/demux_router_pkg.sv - shared constants and select-width helper for demux_router
package demux_router_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

  function automatic int sel_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/demux_router_if.sv
// rtl/demux_router_if.sv - producer-side stream plus per-channel consumer streams
interface demux_router_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4
);

  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry holding register for a single output channel
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Load wins over drain so a simultaneous pop/push keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (r_valid && i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

endmodule

// File: rtl/demux_router.sv
// rtl/demux_router.sv - registered 1xN stream demultiplexer, direct or round-robin steering
module demux_router
  import demux_router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_enable,
  input  logic                        i_mode,
  input  logic [sel_width(N_OUT)-1:0] i_select,
  output logic                        o_drop,
  output logic [sel_width(N_OUT)-1:0] o_rr_ptr,
  demux_router_if.slave               bus
);

  localparam int                 SEL_W    = sel_width(N_OUT);
  localparam logic [SEL_W:0]     LP_N_OUT = (SEL_W + 1)'(N_OUT);
  localparam logic [SEL_W-1:0]   LP_LAST  = SEL_W'(N_OUT - 1);

  logic [SEL_W-1:0]  r_rr_ptr;
  logic              r_drop;

  logic [SEL_W-1:0]  w_dest;
  logic              w_oor;
  logic              w_free;
  logic              w_ready;
  logic              w_fire;
  logic [N_OUT-1:0]  w_load;
  logic [N_OUT-1:0]  w_slot_valid;
  logic [DATA_W-1:0] w_slot_data [N_OUT];

  assign w_dest = (i_mode == MODE_ROTATE) ? r_rr_ptr : i_select;
  assign w_oor  = ({1'b0, w_dest} >= LP_N_OUT);

  // An out-of-range destination is always free: the beat is swallowed.
  always_comb begin
    w_free = 1'b1;
    for (int i = 0; i < N_OUT; i++) begin
      if (w_dest == SEL_W'(i)) begin
        w_free = ~w_slot_valid[i] | bus.out_ready[i];
      end
    end
  end

  assign w_ready = rst_n & i_enable & w_free;
  assign w_fire  = bus.in_valid & w_ready;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (w_dest == SEL_W'(i)) begin
        w_load[i] = w_fire;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_fire & w_oor;
      if (w_fire && (i_mode == MODE_ROTATE)) begin
        r_rr_ptr <= (r_rr_ptr == LP_LAST) ? '0 : r_rr_ptr + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load[g]),
      .i_load_data (bus.in_data),
      .i_out_ready (bus.out_ready[g]),
      .o_out_valid (w_slot_valid[g]),
      .o_out_data  (w_slot_data[g])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      bus.out_data[i*DATA_W +: DATA_W] = w_slot_data[i];
    end
  end

  assign bus.out_valid = w_slot_valid;
  assign bus.in_ready  = w_ready;
  assign o_drop        = r_drop;
  assign o_rr_ptr      = r_rr_ptr;

endmodule

// File: tb/tb_demux_router.sv
// tb/tb_demux_router.sv - self-checking bench for demux_router (N_OUT=4 and N_OUT=3 instances)
module tb_demux_router;

  logic       clk;
  logic       rst_n;
  logic       en4, mode4, drop4;
  logic [1:0] sel4, rr4;
  logic       en3, mode3, drop3;
  logic [1:0] sel3, rr3;

  int errors = 0;
  int checks = 0;

  demux_router_if #(.DATA_W(8), .N_OUT(4)) if4 ();
  demux_router_if #(.DATA_W(8), .N_OUT(3)) if3 ();

  demux_router #(.DATA_W(8), .N_OUT(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (en4),
    .i_mode   (mode4),
    .i_select (sel4),
    .o_drop   (drop4),
    .o_rr_ptr (rr4),
    .bus      (if4)
  );

  demux_router #(.DATA_W(8), .N_OUT(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (en3),
    .i_mode   (mode3),
    .i_select (sel3),
    .o_drop   (drop3),
    .o_rr_ptr (rr3),
    .bus      (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state for the 4-channel instance: what each consumer should see.
  logic [3:0] m_valid;
  logic [7:0] m_data [4];
  int         m_rr;
  logic       m_drop;

  task automatic model_reset();
    m_valid = '0;
    for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
    m_rr   = 0;
    m_drop = 1'b0;
  endtask

  task automatic drive4(input logic v, input logic [7:0] d, input logic [1:0] s,
                        input logic m, input logic e, input logic [3:0] r);
    if4.in_valid  = v;
    if4.in_data   = d;
    sel4          = s;
    mode4         = m;
    en4           = e;
    if4.out_ready = r;
  endtask

  // Called at posedge+1 after drive4; checks in_ready, advances one clock, checks outputs.
  task automatic step4(input string tag);
    int          dest;
    logic        exp_rdy;
    logic        fire;
    logic [31:0] exp_data;
    #1;
    dest    = mode4 ? m_rr : int'(sel4);
    exp_rdy = en4 && ((dest >= 4) || !m_valid[dest[1:0]] || if4.out_ready[dest[1:0]]);
    checks++;
    if (if4.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s in_ready: got %b expected %b", tag, if4.in_ready, exp_rdy);
    end
    fire = if4.in_valid && exp_rdy;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (fire && dest == c) begin
        m_valid[c] = 1'b1;
        m_data[c]  = if4.in_data;
      end else if (m_valid[c] && if4.out_ready[c]) begin
        m_valid[c] = 1'b0;
      end
    end
    m_drop = fire && (dest >= 4);
    if (fire && mode4) m_rr = (m_rr + 1) % 4;
    for (int c = 0; c < 4; c++) exp_data[c*8 +: 8] = m_data[c];
    checks++;
    if (if4.out_valid !== m_valid) begin
      errors++;
      $display("FAIL %s out_valid: got %b expected %b", tag, if4.out_valid, m_valid);
    end
    checks++;
    if (if4.out_data !== exp_data) begin
      errors++;
      $display("FAIL %s out_data: got %h expected %h", tag, if4.out_data, exp_data);
    end
    checks++;
    if (rr4 !== 2'(m_rr)) begin
      errors++;
      $display("FAIL %s rr_ptr: got %0d expected %0d", tag, rr4, m_rr);
    end
    checks++;
    if (drop4 !== m_drop) begin
      errors++;
      $display("FAIL %s drop: got %b expected %b", tag, drop4, m_drop);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (if4.out_valid !== 4'b0000 || if4.out_data !== 32'h0 || rr4 !== 2'd0 || drop4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4 state: valid=%b data=%h rr=%0d drop=%b expected all zero",
               if4.out_valid, if4.out_data, rr4, drop4);
    end
    checks++;
    if (if4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset4 in_ready: got %b expected 0", if4.in_ready);
    end
    checks++;
    if (if3.out_valid !== 3'b000 || if3.in_ready !== 1'b0 || rr3 !== 2'd0) begin
      errors++;
      $display("FAIL reset3 state: valid=%b in_ready=%b rr=%0d expected zero",
               if3.out_valid, if3.in_ready, rr3);
    end
  endtask

  task automatic test_direct();
    drive4(1'b1, 8'hA1, 2'd2, 1'b0, 1'b1, 4'b1111);
    step4("direct_load");
    checks++;
    if (if4.out_valid !== 4'b0100 || if4.out_data[23:16] !== 8'hA1) begin
      errors++;
      $display("FAIL direct_ch2: valid=%b data=%h expected 0100 / a1",
               if4.out_valid, if4.out_data[23:16]);
    end
    drive4(1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 4'b1111);
    step4("direct_drain");
    checks++;
    if (if4.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL direct_drain_valid: got %b expected 0000", if4.out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive4(1'b1, 8'h11, 2'd1, 1'b0, 1'b1, 4'b1101);
    step4("bp_first");
    drive4(1'b1, 8'h22, 2'd1, 1'b0, 1'b1, 4'b1101);
    step4("bp_stall1");
    step4("bp_stall2");
    checks++;
    if (if4.out_data[15:8] !== 8'h11) begin
      errors++;
      $display("FAIL bp_hold: channel 1 got %h expected 11", if4.out_data[15:8]);
    end
    drive4(1'b1, 8'h33, 2'd3, 1'b0, 1'b1, 4'b1101);
    step4("bp_other_channel");
    drive4(1'b1, 8'h22, 2'd1, 1'b0, 1'b1, 4'b1111);
    step4("bp_release");
    checks++;
    if (if4.out_data[15:8] !== 8'h22 || !if4.out_valid[1]) begin
      errors++;
      $display("FAIL bp_second: channel 1 got %h valid %b expected 22 / 1",
               if4.out_data[15:8], if4.out_valid[1]);
    end
    drive4(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 4'b1111);
    step4("bp_idle");
  endtask

  task automatic test_rotate();
    for (int i = 0; i < 6; i++) begin
      drive4(1'b1, 8'(i), 2'd0, 1'b1, 1'b1, 4'b1111);
      step4("rotate_beat");
      checks++;
      if (if4.out_valid !== 4'(1 << (i % 4)) || if4.out_data[(i % 4)*8 +: 8] !== 8'(i)) begin
        errors++;
        $display("FAIL rotate_dest beat %0d: valid=%b expected channel %0d", i, if4.out_valid, i % 4);
      end
    end
    checks++;
    if (rr4 !== 2'd2) begin
      errors++;
      $display("FAIL rotate_end_ptr: got %0d expected 2", rr4);
    end
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, 8'hEE, 2'd0, 1'b1, 1'b0, 4'b1111);
      step4("rotate_disabled");
    end
    checks++;
    if (rr4 !== 2'd2) begin
      errors++;
      $display("FAIL rotate_frozen_ptr: got %0d expected 2", rr4);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive4(1'b1, 8'h40 + 8'(i), 2'd0, 1'b0, 1'b1, 4'b1111);
      step4("b2b_beat");
      checks++;
      if (!if4.out_valid[0] || if4.out_data[7:0] !== 8'h40 + 8'(i)) begin
        errors++;
        $display("FAIL b2b_stream beat %0d: valid=%b data=%h expected 1 / %h",
                 i, if4.out_valid[0], if4.out_data[7:0], 8'h40 + 8'(i));
      end
    end
    drive4(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 4'b1111);
    step4("b2b_idle");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive4(1'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 7) != 0), 4'($urandom));
      step4("random");
    end
  endtask

  task automatic test_out_of_range();
    en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3;
    if3.in_valid = 1'b1; if3.in_data = 8'h5A; if3.out_ready = 3'b111;
    #1;
    checks++;
    if (if3.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready: got %b expected 1", if3.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (drop3 !== 1'b1 || if3.out_valid !== 3'b000) begin
      errors++;
      $display("FAIL oor_drop: drop=%b valid=%b expected 1 / 000", drop3, if3.out_valid);
    end
    if3.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (drop3 !== 1'b0 || if3.out_valid !== 3'b000) begin
      errors++;
      $display("FAIL oor_pulse_end: drop=%b valid=%b expected 0 / 000", drop3, if3.out_valid);
    end
    sel3 = 2'd2; if3.in_valid = 1'b1; if3.in_data = 8'h77;
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    checks++;
    if (if3.out_valid !== 3'b100 || if3.out_data[23:16] !== 8'h77 || drop3 !== 1'b0) begin
      errors++;
      $display("FAIL oor_top_channel: valid=%b data=%h drop=%b expected 100 / 77 / 0",
               if3.out_valid, if3.out_data[23:16], drop3);
    end
    mode3 = 1'b1; if3.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rr3 !== 2'((k + 1) % 3) || drop3 !== 1'b0) begin
        errors++;
        $display("FAIL oor_rotate_wrap beat %0d: rr=%0d drop=%b expected %0d / 0",
                 k, rr3, drop3, (k + 1) % 3);
      end
    end
    if3.in_valid = 1'b0; en3 = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4 && m_rr != 2; k++) begin
      drive4(1'b1, 8'h90, 2'd0, 1'b1, 1'b1, 4'b1111);
      step4("ar_align");
    end
    drive4(1'b1, 8'hC0, 2'd0, 1'b0, 1'b1, 4'b0000);
    step4("ar_hold0");
    drive4(1'b1, 8'hC1, 2'd1, 1'b0, 1'b1, 4'b0000);
    step4("ar_hold1");
    checks++;
    if (if4.out_valid[1:0] !== 2'b11 || rr4 !== 2'd2) begin
      errors++;
      $display("FAIL ar_setup: valid=%b rr=%0d expected xx11 / 2", if4.out_valid, rr4);
    end
    drive4(1'b1, 8'hC2, 2'd2, 1'b0, 1'b1, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if4.out_valid !== 4'b0000 || if4.out_data !== 32'h0 || rr4 !== 2'd0 || if4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate: valid=%b data=%h rr=%0d in_ready=%b expected 0/0/0/0",
               if4.out_valid, if4.out_data, rr4, if4.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive4(1'b1, 8'hD3, 2'd3, 1'b0, 1'b1, 4'b1111);
    step4("ar_after");
  endtask

  initial begin
    rst_n = 1'b0;
    drive4(1'b1, 8'h00, 2'd0, 1'b0, 1'b1, 4'b1111);
    en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0;
    if3.in_valid = 1'b1; if3.in_data = 8'h00; if3.out_ready = 3'b111;
    model_reset();
    test_reset();
    en3 = 1'b0; if3.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive4(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 4'b1111);
    test_direct();
    test_backpressure();
    test_rotate();
    test_back_to_back();
    test_random();
    test_out_of_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Parametrised, registered successor to the gate-level 1x2/1x4 demultiplexers.
- Steers one DATA_W-wide input stream to one of N_OUT output channels, with a valid/ready handshake on each side.
- Each output channel has a one-entry holding register.
- Destination comes from an external select (direct mode) or an internal round-robin pointer (rotate mode).
- Sits between a single producer and N_OUT independent consumers in the datapath.

Parameters:
- DATA_W, 8, width of the payload.
- N_OUT, 4, number of output channels; 2..16, power of two not required.
- SEL_W, $clog2(N_OUT), select width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  global enable; when 0, no input is accepted.
- mode  in  1  0 = direct (use select), 1 = rotate (use internal pointer).
- select  in  SEL_W  destination channel in direct mode.
- in_data  in  DATA_W  input payload.
- in_valid  in  1  producer has data.
- in_ready  out  1  block accepts data this cycle.
- out_data  out  N_OUT*DATA_W  per-channel payload; channel i is at [i*DATA_W +: DATA_W].
- out_valid  out  N_OUT  per-channel valid.
- out_ready  in  N_OUT  per-channel consumer ready.
- drop  out  1  one-cycle pulse when a transfer went to an out-of-range channel.
- rr_ptr  out  SEL_W  current round-robin pointer, for observability.

Behaviour:
- **Reset:** one clock (clk). Reset is asynchronous and active-low (rst_n).
  - While rst_n = 0: out_valid = 0, out_data = 0, rr_ptr = 0, drop = 0.
  - in_ready = 0 during reset.
  - Reset mid-operation discards all held data immediately.
- **Destination:**
  - dest = select when mode = 0; dest = rr_ptr when mode = 1.
  - mode is sampled combinationally each cycle.
  - rr_ptr keeps its value across mode changes.
- **in_ready:** combinational.
  - in_ready = enable & (dest >= N_OUT | ~out_valid[dest] | out_ready[dest]).
  - in_ready does not depend on in_valid.
- **Accept:** in_fire = in_valid & in_ready.
- **Channel i register, priority top-down:**
  - If in_fire & dest == i: load out_data[i] = in_data, set out_valid[i] = 1 on the next edge. Latency is 1 cycle.
  - Else if out_valid[i] & out_ready[i]: clear out_valid[i]. out_data[i] holds its last value.
  - Else: hold.
  - Simultaneous drain and load on the same channel gives back-to-back throughput: valid stays 1 and the new data replaces the old.
- **Independence:**
  - A channel holding unconsumed data stalls only transfers addressed to it.
  - Other channels continue to drain independently.
- **Out-of-range destination** (dest >= N_OUT, only possible when N_OUT is not a power of two):
  - The transfer is accepted and discarded.
  - drop = 1 on the next cycle for one cycle.
  - No out_valid changes.
- **Rotate pointer:**
  - rr_ptr advances only on in_fire while mode = 1.
  - rr_ptr wraps from N_OUT-1 to 0.
  - rr_ptr never holds a value >= N_OUT, so rotate mode never drops.
- **enable = 0:**
  - in_ready = 0; rr_ptr is frozen.
  - Held outputs still drain normally.
- **Ordering:** data to one channel stays in order; there is no ordering guarantee across channels.
- **Protocol:** out_valid and out_data for a channel must not change while out_valid = 1 and out_ready = 0.

Decomposition:
- **Package demux_router_pkg:**
  - Constants MODE_DIRECT = 1'b0 and MODE_ROTATE = 1'b1.
  - Function for the derived SEL_W.
- **Sub-module demux_out_slot:** the one-entry register per channel.
  - Ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data.
  - Instantiated N_OUT times in a generate loop.
- **Top level** holds only dest selection, the in_ready mux, rr_ptr and the drop flag.

Test Plan:
1. **Direct mode:** N_OUT = 4, out_ready = 4'b1111, mode = 0; send 0xA1 with select = 2 → cycle+1: out_valid = 4'b0100, channel 2 data = 0xA1, cycle+2: out_valid = 0.
2. **Backpressure:** out_ready[1] = 0; send 0x11 then 0x22, both with select = 1 → 0x11 held on channel 1, in_ready = 0 while select = 1. Switch select = 3 → in_ready = 1 and 0x33 reaches channel 3. Raise out_ready[1] → 0x22 accepted next.
3. **Rotate:** mode = 1, all outputs ready, 6 consecutive beats 0x00..0x05 → delivered to channels 0,1,2,3,0,1; rr_ptr ends at 2. Hold enable = 0 for 3 cycles → rr_ptr stays 2 and in_ready = 0.
4. **Full throughput:** channel 0 held valid, out_ready[0] = 1, select = 0, in_valid = 1 continuously for 8 beats → out_valid[0] stays 1 and 8 distinct beats emerge at 1 per cycle.
5. **Out-of-range:** N_OUT = 3, select = 3, in_valid = 1 → in_ready = 1, drop pulses for one cycle, out_valid stays 3'b000.
6. **Async reset:** assert rst_n = 0 mid-cycle with 2 channels holding data and rr_ptr = 2 → out_valid = 0, rr_ptr = 0 and in_ready = 0 immediately, without waiting for a clock edge.
